// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: a shift-add multiply step or a restoring
// shift-subtract divide step on the {hi,lo} working pair.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {hi_i, lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    hi_o    = '0;
    lo_o    = '0;
    if (is_div) begin
      // diff's top bit is set exactly when the shifted remainder is below the divisor
      if (!diff[WIDTH]) begin
        hi_o = diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO,
// one datapath step per RUN cycle and sign fix-up on the DONE-entry edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             zdiv_q, zdiv_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;

  logic             is_div_in, is_signed_in, a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    is_div_in    = (op == OP_DIVU) || (op == OP_DIV);
    is_signed_in = (op == OP_MULT) || (op == OP_DIV);
    a_neg        = is_signed_in & a[WIDTH-1];
    b_neg        = is_signed_in & b[WIDTH-1];
    a_mag        = a_neg ? -a : a;
    b_mag        = b_neg ? -b : b;
    accept       = start && (state_q != ST_RUN);
    prod_fix     = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    q_fix        = neg_res_q ? -acc_lo_q : acc_lo_q;
    r_fix        = neg_rem_q ? -acc_hi_q : acc_hi_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zdiv_d    = zdiv_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (hilo_we) begin
          if (hilo_sel) hi_d = hilo_wdata;
          else          lo_d = hilo_wdata;
        end
        if (accept) begin
          // Work on magnitudes; signs are reapplied when the result is committed
          state_d   = ST_RUN;
          cnt_d     = '0;
          is_div_d  = is_div_in;
          opnd_d    = is_div_in ? b_mag : a_mag;
          acc_hi_d  = '0;
          acc_lo_d  = is_div_in ? a_mag : b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          zdiv_d    = is_div_in && (b == '0);
          a_d       = a;
          dbz_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dbz_d   = zdiv_q;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (zdiv_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zdiv_q    <= zdiv_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hilo_we;
  logic         hilo_sel;
  logic [W-1:0] hilo_wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbz;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;
  logic done_seen;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .dbz        (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one operation, scramble the operand inputs after acceptance, and
  // return the number of cycles from the accepting edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cycles);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    chk("busy_after_accept", 64'(busy), 64'd1);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic next_cycle_quiet();
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_dbz",  64'(dbz),  64'd0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_max_latency", 64'(lat), 64'd33);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    next_cycle_quiet();
    chk("idle_not_busy", 64'(busy), 64'd0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);
    next_cycle_quiet();

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
    chk("mult_m3_5_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_m3_5_lo", 64'(lo), 64'hFFFF_FFF1);
    next_cycle_quiet();

    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    chk("divu_100_7_lo", 64'(lo), 64'd14);
    chk("divu_100_7_hi", 64'(hi), 64'd2);
    next_cycle_quiet();

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat);
    chk("div_7_m2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_7_m2_hi", 64'(hi), 64'd1);
    next_cycle_quiet();

    run_op(OP_DIVU, 32'd5, 32'd0, lat);
    chk("divu_5_0_latency", 64'(lat), 64'd33);
    chk("divu_5_0_lo",  64'(lo),  64'hFFFF_FFFF);
    chk("divu_5_0_hi",  64'(hi),  64'd5);
    chk("divu_5_0_dbz", 64'(dbz), 64'd1);
    // Back-to-back start while in DONE; the accepting edge must clear dbz
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_cleared_on_start", 64'(dbz), 64'd0);
    chk("done_to_run_busy", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("multu_2_3_latency", 64'(lat), 64'd33);
    chk("multu_2_3_lo", 64'(lo), 64'd6);
    next_cycle_quiet();

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_min_m1_lo",  64'(lo),  64'h8000_0000);
    chk("div_min_m1_hi",  64'(hi),  64'd0);
    chk("div_min_m1_dbz", 64'(dbz), 64'd0);
    next_cycle_quiet();

    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h11;
    @(posedge clk); #1;
    hilo_sel = 1'b0; hilo_wdata = 32'h22;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    chk("preload_hi", 64'(hi), 64'h11);
    chk("preload_lo", 64'(lo), 64'h22);

    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      start = (k == 3);
      if (k == 3) begin op = OP_DIVU; a = 32'd9; b = 32'd9; end
      hilo_we = (k == 5); hilo_sel = 1'b0; hilo_wdata = 32'h99;
      flush = (k == 10);
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    start = 1'b0; hilo_we = 1'b0; flush = 1'b0;
    chk("flush_busy_low", 64'(busy), 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hi_held", 64'(hi), 64'h11);
    chk("flush_lo_held", 64'(lo), 64'h22);

    run_op(OP_MULTU, 32'hABCD, 32'h1234, lat);
    next_cycle_quiet();
    start = 1'b1; op = OP_MULTU; a = 32'hFFFF; b = 32'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_hi",   64'(hi),   64'd0);
    chk("async_rst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_MULTU, 32'd6, 32'd7, lat);
    chk("post_rst_latency", 64'(lat), 64'd33);
    chk("post_rst_lo", 64'(lo), 64'd42);
    chk("post_rst_hi", 64'(hi), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width (derived, not overridden).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin operation op on a, b.
REQ-006 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands (multiplicand/dividend a, multiplier/divisor b).
REQ-008 SHALL have port flush  input  1  abort operation in progress.
REQ-009 SHALL have ports hilo_we  input  1, hilo_sel  input  1 (0 LO, 1 HI), hilo_wdata  input  WIDTH  direct HI/LO write (mthi/mtlo).
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-013 SHALL have port dbz  output  1  last division had zero divisor.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when counter reaches WIDTH; DONE->IDLE, or DONE->RUN if start high.
REQ-015 SHALL accept start only in IDLE or DONE; start while in RUN SHALL be ignored.
REQ-016 SHALL latch a, b, op at the accepting edge; later operand changes SHALL have no effect.
REQ-017 SHALL assert busy in RUN only; busy SHALL be 1 the cycle after the accepting edge.
REQ-018 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, WIDTH steps total, for every operand value including zero.
REQ-019 SHALL update hi/lo and assert done for exactly one cycle WIDTH+1 cycles after the accepting edge; hi/lo SHALL otherwise hold.
REQ-020 SHALL produce {hi,lo} = 2*WIDTH-bit product for MULT/MULTU; signed form via magnitudes, result negated when operand signs differ.
REQ-021 SHALL produce lo = quotient, hi = remainder for DIV/DIVU; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 SHALL, on divide with b==0, give lo = all ones, hi = a, dbz = 1; full latency retained.
REQ-023 SHALL give lo = MIN_INT, hi = 0 for DIV of MIN_INT by -1, with no flag.
REQ-024 SHALL clear dbz on every accepted start; dbz SHALL otherwise hold.
REQ-025 SHALL apply hilo_we writes only when not in RUN; writes in RUN SHALL be dropped; if hilo_we coincides with the DONE-entry update, the operation result SHALL win.
REQ-026 SHALL, on flush in RUN, return to IDLE next edge, leave hi/lo/dbz unchanged, and not assert done; flush SHALL have no effect outside RUN and SHALL take priority over start on the same edge.

Reset
REQ-027 SHALL on rst force state IDLE, counter 0, hi = lo = 0, busy = 0, done = 0, dbz = 0, asynchronously, including mid-operation.
REQ-028 SHALL resume normal start acceptance on the first rising clk edge after rst deasserts.

Structure
REQ-029 SHALL place op encodings and the state enumeration in a shared package muldiv_pkg.
REQ-030 SHALL isolate the per-cycle iteration datapath in one sub-module muldiv_step (combinational; inputs partial remainder/product, operand, mode; outputs next values).

Verification
REQ-031 SHALL check MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the accepting edge.
REQ-032 SHALL check DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 SHALL check DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, dbz=1; next accepted start clears dbz.
REQ-034 SHALL check DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-035 SHALL check hi=0x11, lo=0x22 preloaded via hilo_we; start, second start at cycle 3 ignored, hilo_we at cycle 5 dropped, flush at cycle 10 -> busy=0 next cycle, no done, hi/lo still 0x11/0x22.
REQ-036 SHALL check rst asserted mid-RUN between clock edges -> immediate busy=0, hi=lo=0; new MULTU 6*7 after release -> lo=42, hi=0.
